// File: rtl/instr_register_pipe.sv
// instr_register_pipe: pipelined instruction register. Accepted writes are
// computed by a signed ALU (results widened to 2*OP_W), committed into a
// DEPTH-entry register file one edge later, and any entry can be returned
// through a registered read port.
// Optional feature macro: IR_ITERATIVE_DIV_EN replaces the combinational
// DIV/MOD path with an OP_W-step restoring divider (IDLE/DIVIDE/COMMIT FSM).
module instr_register_pipe #(
    parameter int unsigned  OP_W   = 32,
    parameter int unsigned  DEPTH  = 32,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] write_pointer,
    input  logic [3:0]        opcode,
    input  logic [OP_W-1:0]   operand_a,
    input  logic [OP_W-1:0]   operand_b,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] read_pointer,
    output logic              rd_valid,
    output logic [3:0]        rd_opcode,
    output logic [OP_W-1:0]   rd_operand_a,
    output logic [OP_W-1:0]   rd_operand_b,
    output logic [2*OP_W-1:0] rd_result,
    output logic              rd_err,
    output logic              rd_written
);

    localparam int unsigned RES_W = 2 * OP_W;

    typedef enum logic [3:0] {
        OP_ZERO  = 4'd0,
        OP_PASSA = 4'd1,
        OP_PASSB = 4'd2,
        OP_ADD   = 4'd3,
        OP_SUB   = 4'd4,
        OP_MULT  = 4'd5,
        OP_DIV   = 4'd6,
        OP_MOD   = 4'd7
    } opcode_e;

    // Two's-complement magnitude; the most negative value maps to 2^(OP_W-1).
    function automatic logic [OP_W-1:0] magnitude(input logic [OP_W-1:0] v);
        return v[OP_W-1] ? (~v + OP_W'(1)) : v;
    endfunction

    // Zero-extend an unsigned magnitude to RES_W, then negate if required.
    function automatic logic [RES_W-1:0] signed_widen(input logic [OP_W-1:0] m,
                                                      input logic          neg);
        logic [RES_W-1:0] w;
        w = {{OP_W{1'b0}}, m};
        return neg ? (~w + RES_W'(1)) : w;
    endfunction

    logic              accept;
    logic              ready_q;

    logic              s1_valid_q, s1_valid_d;
    logic [3:0]        s1_op_q, s1_op_d;
    logic [OP_W-1:0]   s1_a_q, s1_a_d;
    logic [OP_W-1:0]   s1_b_q, s1_b_d;
    logic [ADDR_W-1:0] s1_ptr_q, s1_ptr_d;
    logic [RES_W-1:0]  s1_res;
    logic              s1_err;
    logic [RES_W-1:0]  ext_a, ext_b;

    logic              cm_en;
    logic [ADDR_W-1:0] cm_ptr;
    logic [3:0]        cm_op;
    logic [OP_W-1:0]   cm_a, cm_b;
    logic [RES_W-1:0]  cm_res;
    logic              cm_err;

    logic [3:0]        mem_op_q  [DEPTH];
    logic [OP_W-1:0]   mem_a_q   [DEPTH];
    logic [OP_W-1:0]   mem_b_q   [DEPTH];
    logic [RES_W-1:0]  mem_res_q [DEPTH];
    logic              mem_err_q [DEPTH];
    logic              mem_wr_q  [DEPTH];

    logic              rd_valid_q;
    logic [3:0]        rd_op_q;
    logic [OP_W-1:0]   rd_a_q, rd_b_q;
    logic [RES_W-1:0]  rd_res_q;
    logic              rd_err_q, rd_wr_q;

`ifdef IR_ITERATIVE_DIV_EN
    localparam int unsigned CNT_W = (OP_W > 1) ? $clog2(OP_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIVIDE,
        S_COMMIT
    } div_state_e;

    div_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        dv_op_q, dv_op_d;
    logic [OP_W-1:0]   dv_a_q, dv_a_d;
    logic [OP_W-1:0]   dv_b_q, dv_b_d;
    logic [ADDR_W-1:0] dv_ptr_q, dv_ptr_d;
    logic [OP_W-1:0]   dv_dvs_q, dv_dvs_d;
    logic [OP_W-1:0]   dv_quo_q, dv_quo_d;
    logic [OP_W-1:0]   dv_rem_q, dv_rem_d;
    logic [OP_W:0]     rem_shift;
    logic [RES_W-1:0]  dv_res;
    logic              div_start;

    // Ready only while the divider is idle.
    always_comb wr_ready = ready_q && (state_q == S_IDLE);

    // A DIV/MOD with a non-zero divisor goes to the iterative divider.
    always_comb div_start = accept && ((opcode == OP_DIV) || (opcode == OP_MOD))
                            && (operand_b != '0);
`else
    // Ready from the first edge after reset; single-cycle ops never stall.
    always_comb wr_ready = ready_q;
`endif

    // Handshake: a write is taken on an edge where valid and ready meet.
    always_comb accept = wr_valid && wr_ready;

    // Ready register: low while reset is held.
    always_ff @(posedge clk) begin
        if (reset) ready_q <= 1'b0;
        else       ready_q <= 1'b1;
    end

    // Stage-1 next state: capture the accepted write.
    always_comb begin
        s1_valid_d = accept;
`ifdef IR_ITERATIVE_DIV_EN
        if (div_start) s1_valid_d = 1'b0;
`endif
        s1_op_d  = s1_op_q;
        s1_a_d   = s1_a_q;
        s1_b_d   = s1_b_q;
        s1_ptr_d = s1_ptr_q;
        if (accept) begin
            s1_op_d  = opcode;
            s1_a_d   = operand_a;
            s1_b_d   = operand_b;
            s1_ptr_d = write_pointer;
        end
    end

    // Stage-1 registers; reset discards any in-flight write.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_ptr_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_ptr_q   <= s1_ptr_d;
        end
    end

`ifndef IR_ITERATIVE_DIV_EN
    logic [OP_W-1:0] mag_a, mag_b, quo, rem;

    // Combinational divider on magnitudes; signs are restored afterwards so
    // that MIN / -1 yields +2^(OP_W-1) without overflow.
    always_comb begin
        mag_a = magnitude(s1_a_q);
        mag_b = magnitude(s1_b_q);
        quo   = '0;
        rem   = '0;
        if (mag_b != '0) begin
            quo = mag_a / mag_b;
            rem = mag_a % mag_b;
        end
    end
`endif

    // Stage-1 ALU: signed result widened to 2*OP_W plus error flag.
    always_comb begin
        ext_a  = {{OP_W{s1_a_q[OP_W-1]}}, s1_a_q};
        ext_b  = {{OP_W{s1_b_q[OP_W-1]}}, s1_b_q};
        s1_res = '0;
        s1_err = 1'b0;
        case (s1_op_q)
            OP_ZERO:  s1_res = '0;
            OP_PASSA: s1_res = ext_a;
            OP_PASSB: s1_res = ext_b;
            OP_ADD:   s1_res = ext_a + ext_b;
            OP_SUB:   s1_res = ext_a - ext_b;
            OP_MULT:  s1_res = ext_a * ext_b;
`ifdef IR_ITERATIVE_DIV_EN
            // Only zero-divisor divisions take the stage-1 path here.
            OP_DIV, OP_MOD: s1_err = 1'b1;
`else
            OP_DIV: begin
                if (s1_b_q == '0) s1_err = 1'b1;
                else s1_res = signed_widen(quo, s1_a_q[OP_W-1] ^ s1_b_q[OP_W-1]);
            end
            OP_MOD: begin
                if (s1_b_q == '0) s1_err = 1'b1;
                else s1_res = signed_widen(rem, s1_a_q[OP_W-1]);
            end
`endif
            default:  s1_err = 1'b1;
        endcase
    end

`ifdef IR_ITERATIVE_DIV_EN
    // Divider FSM next state: load magnitudes, OP_W restoring steps, commit.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dv_op_d   = dv_op_q;
        dv_a_d    = dv_a_q;
        dv_b_d    = dv_b_q;
        dv_ptr_d  = dv_ptr_q;
        dv_dvs_d  = dv_dvs_q;
        dv_quo_d  = dv_quo_q;
        dv_rem_d  = dv_rem_q;
        rem_shift = {dv_rem_q, dv_quo_q[OP_W-1]};
        case (state_q)
            S_IDLE: begin
                if (div_start) begin
                    state_d  = S_DIVIDE;
                    cnt_d    = '0;
                    dv_op_d  = opcode;
                    dv_a_d   = operand_a;
                    dv_b_d   = operand_b;
                    dv_ptr_d = write_pointer;
                    dv_dvs_d = magnitude(operand_b);
                    dv_quo_d = magnitude(operand_a);
                    dv_rem_d = '0;
                end
            end
            S_DIVIDE: begin
                // Quotient register doubles as the dividend shifter.
                if (rem_shift >= {1'b0, dv_dvs_q}) begin
                    dv_rem_d = OP_W'(rem_shift - {1'b0, dv_dvs_q});
                    dv_quo_d = {dv_quo_q[OP_W-2:0], 1'b1};
                end else begin
                    dv_rem_d = rem_shift[OP_W-1:0];
                    dv_quo_d = {dv_quo_q[OP_W-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(OP_W - 1)) state_d = S_COMMIT;
            end
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Divider registers; reset abandons any division in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            dv_op_q  <= '0;
            dv_a_q   <= '0;
            dv_b_q   <= '0;
            dv_ptr_q <= '0;
            dv_dvs_q <= '0;
            dv_quo_q <= '0;
            dv_rem_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dv_op_q  <= dv_op_d;
            dv_a_q   <= dv_a_d;
            dv_b_q   <= dv_b_d;
            dv_ptr_q <= dv_ptr_d;
            dv_dvs_q <= dv_dvs_d;
            dv_quo_q <= dv_quo_d;
            dv_rem_q <= dv_rem_d;
        end
    end

    // Sign correction of the finished division.
    always_comb begin
        if (dv_op_q == OP_MOD) dv_res = signed_widen(dv_rem_q, dv_a_q[OP_W-1]);
        else                   dv_res = signed_widen(dv_quo_q, dv_a_q[OP_W-1] ^ dv_b_q[OP_W-1]);
    end
`endif

    // Commit source select: stage 1, or the divider when it finishes.
    always_comb begin
        cm_en  = s1_valid_q;
        cm_ptr = s1_ptr_q;
        cm_op  = s1_op_q;
        cm_a   = s1_a_q;
        cm_b   = s1_b_q;
        cm_res = s1_res;
        cm_err = s1_err;
`ifdef IR_ITERATIVE_DIV_EN
        if (state_q == S_COMMIT) begin
            cm_en  = 1'b1;
            cm_ptr = dv_ptr_q;
            cm_op  = dv_op_q;
            cm_a   = dv_a_q;
            cm_b   = dv_b_q;
            cm_res = dv_res;
            cm_err = 1'b0;
        end
`endif
    end

    // Register file: cleared on reset, last write wins otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_op_q  <= '{default: '0};
            mem_a_q   <= '{default: '0};
            mem_b_q   <= '{default: '0};
            mem_res_q <= '{default: '0};
            mem_err_q <= '{default: 1'b0};
            mem_wr_q  <= '{default: 1'b0};
        end else if (cm_en) begin
            mem_op_q[cm_ptr]  <= cm_op;
            mem_a_q[cm_ptr]   <= cm_a;
            mem_b_q[cm_ptr]   <= cm_b;
            mem_res_q[cm_ptr] <= cm_res;
            mem_err_q[cm_ptr] <= cm_err;
            mem_wr_q[cm_ptr]  <= 1'b1;
        end
    end

    // Registered read port; a same-edge commit is not visible yet.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_op_q    <= '0;
            rd_a_q     <= '0;
            rd_b_q     <= '0;
            rd_res_q   <= '0;
            rd_err_q   <= 1'b0;
            rd_wr_q    <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_op_q  <= mem_op_q[read_pointer];
                rd_a_q   <= mem_a_q[read_pointer];
                rd_b_q   <= mem_b_q[read_pointer];
                rd_res_q <= mem_res_q[read_pointer];
                rd_err_q <= mem_err_q[read_pointer];
                rd_wr_q  <= mem_wr_q[read_pointer];
            end
        end
    end

    assign rd_valid     = rd_valid_q;
    assign rd_opcode    = rd_op_q;
    assign rd_operand_a = rd_a_q;
    assign rd_operand_b = rd_b_q;
    assign rd_result    = rd_res_q;
    assign rd_err       = rd_err_q;
    assign rd_written   = rd_wr_q;

endmodule

// File: tb/tb_instr_register_pipe.sv
// Testbench for instr_register_pipe: directed cases with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_instr_register_pipe;

    localparam int unsigned OP_W  = 32;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned AW    = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] write_pointer;
    logic [3:0]    opcode;
    logic [31:0]   operand_a, operand_b;
    logic          rd_en;
    logic [AW-1:0] read_pointer;
    logic          rd_valid;
    logic [3:0]    rd_opcode;
    logic [31:0]   rd_operand_a, rd_operand_b;
    logic [63:0]   rd_result;
    logic          rd_err, rd_written;

    always #5 clk = ~clk;

    instr_register_pipe #(.OP_W(OP_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .write_pointer(write_pointer), .opcode(opcode),
        .operand_a(operand_a), .operand_b(operand_b),
        .rd_en(rd_en), .read_pointer(read_pointer), .rd_valid(rd_valid),
        .rd_opcode(rd_opcode), .rd_operand_a(rd_operand_a),
        .rd_operand_b(rd_operand_b), .rd_result(rd_result),
        .rd_err(rd_err), .rd_written(rd_written)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int unsigned   due;
        bit            long_op;
        logic [AW-1:0] ptr;
        logic [3:0]    op;
        logic [31:0]   a;
        logic [31:0]   b;
        logic [63:0]   r;
        bit            e;
    } pend_t;

    pend_t       pq[$];
    logic [3:0]  m_op [DEPTH];
    logic [31:0] m_a  [DEPTH];
    logic [31:0] m_b  [DEPTH];
    logic [63:0] m_r  [DEPTH];
    bit          m_e  [DEPTH];
    bit          m_w  [DEPTH];
    bit          exp_ready = 1'b0;
    bit          exp_rv = 1'b0;
    logic [3:0]  exp_op = '0;
    logic [31:0] exp_a = '0, exp_b = '0;
    logic [63:0] exp_r = '0;
    bit          exp_e = 1'b0, exp_w = 1'b0;
    int unsigned cyc = 0;

    function automatic void golden(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, output logic [63:0] r, output bit e);
        longint sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        r = 64'd0;
        e = 1'b0;
        case (op)
            4'd0: r = 64'd0;
            4'd1: r = sa;
            4'd2: r = sb;
            4'd3: r = sa + sb;
            4'd4: r = sa - sb;
            4'd5: r = sa * sb;
            4'd6: if (sb == 0) e = 1'b1; else r = sa / sb;
            4'd7: if (sb == 0) e = 1'b1; else r = sa % sb;
            default: e = 1'b1;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_op[i] = '0; m_a[i] = '0; m_b[i] = '0; m_r[i] = '0; m_e[i] = 1'b0; m_w[i] = 1'b0;
            end
            pq.delete();
            exp_ready = 1'b0; exp_rv = 1'b0;
            exp_op = '0; exp_a = '0; exp_b = '0; exp_r = '0; exp_e = 1'b0; exp_w = 1'b0;
        end else begin
            exp_rv = rd_en;
            if (rd_en) begin
                exp_op = m_op[read_pointer]; exp_a = m_a[read_pointer]; exp_b = m_b[read_pointer];
                exp_r  = m_r[read_pointer];  exp_e = m_e[read_pointer]; exp_w = m_w[read_pointer];
            end
            for (int i = pq.size() - 1; i >= 0; i--) begin
                if (pq[i].due == cyc) begin
                    m_op[pq[i].ptr] = pq[i].op; m_a[pq[i].ptr] = pq[i].a; m_b[pq[i].ptr] = pq[i].b;
                    m_r[pq[i].ptr] = pq[i].r; m_e[pq[i].ptr] = pq[i].e; m_w[pq[i].ptr] = 1'b1;
                    pq.delete(i);
                end
            end
            if (wr_valid && exp_ready) begin
                pend_t p;
                p.ptr = write_pointer; p.op = opcode; p.a = operand_a; p.b = operand_b;
                golden(opcode, operand_a, operand_b, p.r, p.e);
                p.due = cyc + 1;
                p.long_op = 1'b0;
`ifdef IR_ITERATIVE_DIV_EN
                if ((opcode == 4'd6 || opcode == 4'd7) && operand_b != 32'd0) begin
                    p.due = cyc + OP_W + 1;
                    p.long_op = 1'b1;
                end
`endif
                pq.push_back(p);
            end
            exp_ready = 1'b1;
            foreach (pq[i]) if (pq[i].long_op) exp_ready = 1'b0;
        end
        cyc++;
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        check("wr_ready", 64'(wr_ready), 64'(exp_ready));
        check("rd_valid", 64'(rd_valid), 64'(exp_rv));
        check("rd_opcode", 64'(rd_opcode), 64'(exp_op));
        check("rd_operand_a", 64'(rd_operand_a), 64'(exp_a));
        check("rd_operand_b", 64'(rd_operand_b), 64'(exp_b));
        check("rd_result", rd_result, exp_r);
        check("rd_err", 64'(rd_err), 64'(exp_e));
        check("rd_written", 64'(rd_written), 64'(exp_w));
    end

    // ---------------- stimulus ----------------
    task automatic wr(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [AW-1:0] p);
        int unsigned guard = 0;
        while (!wr_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("wr_ready_wait", 64'(wr_ready), 64'd1);
        wr_valid = 1'b1; opcode = op; operand_a = a; operand_b = b; write_pointer = p;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] p);
        rd_en = 1'b1; read_pointer = p;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4, 5: return 32'($signed($urandom_range(0, 40)) - 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; wr_valid = 1'b0; write_pointer = '0; opcode = '0;
        operand_a = '0; operand_b = '0; rd_en = 1'b0; read_pointer = '0;
        repeat (2) @(negedge clk);
        check("ready_in_reset", 64'(wr_ready), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 64'(wr_ready), 64'd1);

        for (int i = 0; i < DEPTH; i++) begin
            rd(AW'(i));
            check("reset_written", 64'(rd_written), 64'd0);
            check("reset_result", rd_result, 64'd0);
        end

        wr(4'd3, 32'd5, -32'sd7, 5'd3);
        wr(4'd5, -32'sd3, 32'd4, 5'd4);
        wr(4'd7, -32'sd7, 32'd2, 5'd5);
        rd(5'd3); check("add_result", rd_result, 64'hFFFF_FFFF_FFFF_FFFE);
        check("add_written", 64'(rd_written), 64'd1);
        rd(5'd4); check("mult_result", rd_result, 64'hFFFF_FFFF_FFFF_FFF4);
        rd(5'd5); check("mod_result", rd_result, 64'hFFFF_FFFF_FFFF_FFFF);
        check("mod_err", 64'(rd_err), 64'd0);

        wr(4'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
        wr(4'd6, 32'd9, 32'd0, 5'd6);
        wr(4'd12, 32'd1, 32'd2, 5'd8);
        rd(5'd11); check("divmin_result", rd_result, 64'h0000_0000_8000_0000);
        check("divmin_err", 64'(rd_err), 64'd0);
        rd(5'd6); check("div0_result", rd_result, 64'd0);
        check("div0_err", 64'(rd_err), 64'd1);
        rd(5'd8); check("badop_result", rd_result, 64'd0);
        check("badop_err", 64'(rd_err), 64'd1);

        wr(4'd1, 32'd1, 32'd0, 5'd7);
        check("b2b_ready1", 64'(wr_ready), 64'd1);
        wr(4'd1, 32'd2, 32'd0, 5'd7);
        check("b2b_ready2", 64'(wr_ready), 64'd1);
        rd_en = 1'b1; read_pointer = 5'd7;
        @(negedge clk);
        check("same_edge_read", rd_result, 64'd1);
        check("b2b_ready3", 64'(wr_ready), 64'd1);
        @(negedge clk);
        check("next_read", rd_result, 64'd2);
        rd_en = 1'b0;

`ifdef IR_ITERATIVE_DIV_EN
        begin
            int unsigned lows;
            wr(4'd6, 32'd100, 32'd7, 5'd9);
            lows = (wr_ready == 1'b0) ? 1 : 0;
            for (int k = 0; k < OP_W; k++) begin
                @(negedge clk);
                if (!wr_ready) lows++;
            end
            check("div_busy_cycles", 64'(lows), 64'(OP_W + 1));
            @(negedge clk);
            check("div_ready_back", 64'(wr_ready), 64'd1);
            rd(5'd9); check("iter_div_result", rd_result, 64'd14);

            wr(4'd6, 32'd100, 32'd7, 5'd10);
            repeat (5) @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            @(negedge clk);
            check("ready_after_mid_reset", 64'(wr_ready), 64'd1);
            repeat (OP_W + 4) @(negedge clk);
            rd(5'd10); check("mid_reset_written", 64'(rd_written), 64'd0);
            check("mid_reset_result", rd_result, 64'd0);
            rd(5'd9); check("mid_reset_cleared", 64'(rd_written), 64'd0);
        end
`endif

        for (int k = 0; k < 3000; k++) begin
            wr_valid = ($urandom_range(0, 3) != 0);
            opcode = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
            operand_a = pick();
            operand_b = pick();
            write_pointer = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            rd_en = ($urandom_range(0, 1) != 0);
            read_pointer = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            reset = ($urandom_range(0, 399) == 0);
            @(negedge clk);
        end
        wr_valid = 1'b0; rd_en = 1'b0; reset = 1'b0;
        repeat (OP_W + 4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
